// File: rtl/minimig_control_pkg.sv
// Shared definitions for the Minimig control-board bus master:
// op codes, FSM state encoding and fixed response bytes.
package minimig_control_pkg;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_WRW = 2'b01,
      OP_WRL = 2'b10,
      OP_RD  = 2'b11
   } op_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_DHI,
      S_DLO,
      S_STROBE,
      S_CAPTURE,
      S_RSP_HI,
      S_RSP_LO,
      S_RSP_ERR
   } state_t;

   localparam logic [7:0] ACK = 8'h00;
   localparam logic [7:0] ERR = 8'hEE;

endpackage

// File: rtl/minimig_control_master.sv
// Byte-stream command parser that issues single-cycle register bus accesses
// to the control-board slave and streams back an ack, read data or an error.
module minimig_control_master
   import minimig_control_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic [7:0]  rsp_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [14:0] bus_addr,
   output logic [15:0] bus_wdata,
   input  logic [15:0] bus_rdata,
   output logic        bus_sel,
   output logic        bus_rd,
   output logic        bus_hwr,
   output logic        bus_lwr,
   output logic        busy
);

   state_t      state;
   state_t      state_nxt;
   op_t         op;
   logic [7:0]  addr_idx;
   logic [15:0] wdata;
   logic [15:0] rd_reg;
   logic        cmd_hs;
   logic        rsp_hs;

   assign cmd_hs = cmd_valid && cmd_ready;
   assign rsp_hs = rsp_valid && rsp_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Frame fields and read data are captured only on their own handshake/state
   always_ff @(posedge clk) begin
      if (rst) begin
         op       <= OP_NOP;
         addr_idx <= 8'h00;
         wdata    <= 16'h0000;
         rd_reg   <= 16'h0000;
      end else begin
         if (state == S_IDLE && cmd_hs && cmd_data[7:2] == 6'd0)
            op <= op_t'(cmd_data[1:0]);
         if (state == S_ADDR && cmd_hs) addr_idx     <= cmd_data;
         if (state == S_DHI  && cmd_hs) wdata[15:8]  <= cmd_data;
         if (state == S_DLO  && cmd_hs) wdata[7:0]   <= cmd_data;
         if (state == S_CAPTURE)        rd_reg       <= bus_rdata;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (cmd_hs) begin
               if (cmd_data[7:2] != 6'd0)          state_nxt = S_RSP_ERR;
               else if (cmd_data[1:0] == OP_NOP)   state_nxt = S_IDLE;
               else                                state_nxt = S_ADDR;
            end
         S_ADDR:    if (cmd_hs) state_nxt = (op == OP_RD) ? S_STROBE : S_DHI;
         S_DHI:     if (cmd_hs) state_nxt = S_DLO;
         S_DLO:     if (cmd_hs) state_nxt = S_STROBE;
         S_STROBE:  state_nxt = (op == OP_RD) ? S_CAPTURE : S_RSP_LO;
         S_CAPTURE: state_nxt = S_RSP_HI;
         S_RSP_HI:  if (rsp_hs) state_nxt = S_RSP_LO;
         S_RSP_LO:  if (rsp_hs) state_nxt = S_IDLE;
         S_RSP_ERR: if (rsp_hs) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_data  = 8'h00;
      bus_sel   = 1'b0;
      bus_rd    = 1'b0;
      bus_hwr   = 1'b0;
      bus_lwr   = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE, S_ADDR, S_DHI, S_DLO: cmd_ready = 1'b1;
         S_STROBE: begin
            bus_sel = 1'b1;
            bus_rd  = (op == OP_RD);
            bus_hwr = (op == OP_WRW);
            bus_lwr = (op == OP_WRW) || (op == OP_WRL);
         end
         S_RSP_HI: begin
            rsp_valid = 1'b1;
            rsp_data  = rd_reg[15:8];
         end
         S_RSP_LO: begin
            rsp_valid = 1'b1;
            rsp_data  = (op == OP_RD) ? rd_reg[7:0] : ACK;
         end
         S_RSP_ERR: begin
            rsp_valid = 1'b1;
            rsp_data  = ERR;
         end
         default: ;
      endcase
   end

   assign bus_addr  = {7'b0000000, addr_idx};
   assign bus_wdata = wdata;

endmodule

// File: tb/tb_minimig_control_master.sv
// Scoreboard bench for minimig_control_master: expected strobes and response
// bytes are queued as frames are sent and popped as the DUT produces them.
module tb_minimig_control_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  cmd_data = 8'h00;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  rsp_data;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [14:0] bus_addr;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata = 16'h0000;
   logic        bus_sel, bus_rd, bus_hwr, bus_lwr;
   logic        busy;

   always #5 clk = ~clk;

   minimig_control_master dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .rsp_data  (rsp_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_sel   (bus_sel),
      .bus_rd    (bus_rd),
      .bus_hwr   (bus_hwr),
      .bus_lwr   (bus_lwr),
      .busy      (busy)
   );

   typedef struct {
      logic [2:0]  strb;   // {rd, hwr, lwr}
      logic [14:0] addr;
      logic [15:0] wdata;
      bit          is_wr;
   } strb_t;

   strb_t       exp_strb[$];
   logic [7:0]  exp_rsp[$];
   logic [15:0] slave_val = 16'h0000;
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Slave returns registered data one cycle after a read strobe, 0 otherwise
   always @(posedge clk) bus_rdata <= (bus_sel && bus_rd) ? slave_val : 16'h0000;

   always @(negedge clk) begin
      if (bus_sel) begin
         strb_t e;
         if (exp_strb.size() == 0) check("extra_strobe", 1, 0);
         else begin
            e = exp_strb.pop_front();
            check("strb_lines", {29'd0, bus_rd, bus_hwr, bus_lwr}, {29'd0, e.strb});
            check("strb_addr", {17'd0, bus_addr}, {17'd0, e.addr});
            if (e.is_wr) check("strb_wdata", {16'd0, bus_wdata}, {16'd0, e.wdata});
         end
      end else if (bus_rd || bus_hwr || bus_lwr) begin
         check("stray_strobe", {29'd0, bus_rd, bus_hwr, bus_lwr}, 0);
      end
      if (rsp_valid && rsp_ready) begin
         if (exp_rsp.size() == 0) check("extra_rsp", {24'd0, rsp_data}, 32'hFFFF);
         else check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp.pop_front()});
      end
   end

   task automatic send(input logic [7:0] b, input int gap);
      int n;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
      cmd_data  = b;
      cmd_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("cmd_ready_wait", 0, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] idx,
                           input logic [7:0] dhi, input logic [7:0] dlo, input int gap);
      strb_t e;
      e.strb  = (cmd == 8'h01) ? 3'b011 : 3'b001;
      e.addr  = {7'd0, idx};
      e.wdata = {dhi, dlo};
      e.is_wr = 1'b1;
      exp_strb.push_back(e);
      exp_rsp.push_back(8'h00);
      send(cmd, 0);
      send(idx, gap);
      send(dhi, gap);
      send(dlo, gap);
   endtask

   task automatic rd_frame(input logic [7:0] idx, input logic [15:0] val, input int gap);
      strb_t e;
      e.strb  = 3'b100;
      e.addr  = {7'd0, idx};
      e.wdata = 16'h0000;
      e.is_wr = 1'b0;
      slave_val = val;
      exp_strb.push_back(e);
      exp_rsp.push_back(val[15:8]);
      exp_rsp.push_back(val[7:0]);
      send(8'h03, 0);
      send(idx, gap);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300 && (exp_strb.size() != 0 || exp_rsp.size() != 0); i++)
         @(posedge clk);
      check(tag, exp_strb.size() + exp_rsp.size(), 0);
      exp_strb.delete();
      exp_rsp.delete();
      @(negedge clk);
      check({tag, "_idle"}, {31'd0, busy}, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [7:0]  r_idx, r_hi, r_lo;
      logic [15:0] r_val;
      int          r_op, r_gap;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
      check("rst_rsp_data", {24'd0, rsp_data}, 0);
      check("rst_strobes", {28'd0, bus_sel, bus_rd, bus_hwr, bus_lwr}, 0);
      check("rst_bus_addr", {17'd0, bus_addr}, 0);
      check("rst_bus_wdata", {16'd0, bus_wdata}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      @(posedge clk);
      #1;

      wr_frame(8'h01, 8'h08, 8'h12, 8'h34, 0);
      drain("wrw");
      rd_frame(8'h07, 16'h8017, 0);
      drain("rd");
      wr_frame(8'h02, 8'h0C, 8'hFF, 8'h40, 0);
      drain("wrl");

      // Illegal command byte then a normal read
      exp_rsp.push_back(8'hEE);
      send(8'h84, 0);
      rd_frame(8'h00, 16'h1357, 0);
      drain("err");

      // NOP leaves the FSM idle without a bus cycle
      send(8'h00, 0);
      @(negedge clk);
      check("nop_busy", {31'd0, busy}, 0);
      @(posedge clk);
      #1;

      // Response held off for 10 cycles
      rsp_ready = 1'b0;
      rd_frame(8'h05, 16'hA5C3, 0);
      for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
      check("stall_rsp_seen", {31'd0, rsp_valid}, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_rsp_data", {24'd0, rsp_data}, 32'hA5);
         check("stall_cmd_ready", {31'd0, cmd_ready}, 0);
         check("stall_rsp_valid", {31'd0, rsp_valid}, 1);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      drain("stall");

      // Reset in the middle of a write frame aborts it
      send(8'h01, 0);
      send(8'h10, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_cmd_ready", {31'd0, cmd_ready}, 1);
      check("abort_bus_addr", {17'd0, bus_addr}, 0);
      @(posedge clk);
      #1;
      wr_frame(8'h01, 8'h20, 8'hAB, 8'hCD, 0);
      drain("post_abort");

      // Reset landing on the strobe cycle: one strobe, no response, no retry
      wr_frame(8'h01, 8'h30, 8'h11, 8'h22, 0);
      exp_rsp.delete();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("strobe_rst_busy", {31'd0, busy}, 0);
      check("strobe_rst_rsp", {31'd0, rsp_valid}, 0);
      repeat (5) @(posedge clk);
      #1;
      drain("strobe_rst");

      // Gapped frames
      wr_frame(8'h02, 8'h41, 8'h5A, 8'hC3, 4);
      drain("gap_wr");
      rd_frame(8'h42, 16'hBEEF, 6);
      drain("gap_rd");

      // Random frames
      for (int k = 0; k < 8; k++) begin
         r_op  = $urandom_range(1, 3);
         r_idx = 8'($urandom);
         r_hi  = 8'($urandom);
         r_lo  = 8'($urandom);
         r_gap = $urandom_range(0, 2);
         r_val = {r_hi, r_lo};
         if (r_op == 3) rd_frame(r_idx, r_val, r_gap);
         else wr_frame(8'(r_op), r_idx, r_hi, r_lo, r_gap);
         drain("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
